// File: rtl/w_input_conditioner_pkg.sv
// Shared definitions for the switch/button input conditioner.
// Contents:
//   filt_state_e  debounce filter state encoding (STABLE0, PEND1, STABLE1, PEND0)
package w_input_conditioner_pkg;

  // Bit 1 of the encoding is the committed output level in every state.
  typedef enum logic [1:0] {
    ST_STABLE0 = 2'd0,
    ST_PEND1   = 2'd1,
    ST_STABLE1 = 2'd2,
    ST_PEND0   = 2'd3
  } filt_state_e;

endpackage

// File: rtl/w_input_conditioner_if.sv
// Board-side signal bundle of the input conditioner.
// Signals:
//   sw_raw     raw asynchronous slide-switch level
//   btn_raw    raw asynchronous push-button level (1 = pressed)
//   w          debounced switch level
//   btn_level  debounced button level
//   step       one-cycle pulse per debounced button press
// Modports:
//   master  drives the raw levels, observes the conditioned outputs
//   slave   the conditioner itself
interface w_input_conditioner_if;

  logic sw_raw;
  logic btn_raw;
  logic w;
  logic btn_level;
  logic step;

  modport master (
    output sw_raw,
    output btn_raw,
    input  w,
    input  btn_level,
    input  step
  );

  modport slave (
    input  sw_raw,
    input  btn_raw,
    output w,
    output btn_level,
    output step
  );

endinterface

// File: rtl/w_input_conditioner_debounce_filter.sv
// Two-flop synchronizer followed by a debounce FSM with a run-length counter.
// The output only changes after DEBOUNCE_CYCLES consecutive synchronized samples
// at the opposite level; any bounce restarts the count.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-low
//   din_raw  raw asynchronous input level
//   dout     debounced level (decoded from the state register)
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_STABLE0 | output 0, input agrees
// ST_PEND1   | output 0, input has been 1 for cnt samples
// ST_STABLE1 | output 1, input agrees
// ST_PEND0   | output 1, input has been 0 for cnt samples
module w_input_conditioner_debounce_filter
  import w_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit SKIP_PEND = (DEBOUNCE_CYCLES == 1);

  logic             s1;
  logic             s2;
  filt_state_e      state;
  filt_state_e      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_STABLE0;
      cnt   <= '0;
    end else begin
      s1    <= din_raw;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The first differing sample already counts as 1, so a commit happens on
  // the DEBOUNCE_CYCLES-th consecutive sample; a single-sample filter skips PEND.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      ST_STABLE0: begin
        if (s2) begin
          if (SKIP_PEND) begin
            state_nxt = ST_STABLE1;
          end else begin
            state_nxt = ST_PEND1;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_PEND1: begin
        if (!s2) begin
          state_nxt = ST_STABLE0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_STABLE1: begin
        if (!s2) begin
          if (SKIP_PEND) begin
            state_nxt = ST_STABLE0;
          end else begin
            state_nxt = ST_PEND0;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_PEND0: begin
        if (s2) begin
          state_nxt = ST_STABLE1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_STABLE0;
      end
    endcase
  end

  // Pure decode of the state register, so the level is glitch-free.
  always_comb begin
    dout = (state == ST_STABLE1) || (state == ST_PEND0);
  end

endmodule

// File: rtl/w_input_conditioner.sv
// Board-input front end for the sequence-detector FSM: debounces the slide
// switch into w and the push button into btn_level plus a one-cycle step pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   io     slave side of w_input_conditioner_if (raw inputs in, clean levels out)
module w_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  w_input_conditioner_if.slave  io
);

  logic w_lvl;
  logic btn_lvl;
  logic btn_lvl_d;
  logic step_q;

  w_input_conditioner_debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_filter (
    .clk     (clk),
    .reset   (reset),
    .din_raw (io.sw_raw),
    .dout    (w_lvl)
  );

  w_input_conditioner_debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_filter (
    .clk     (clk),
    .reset   (reset),
    .din_raw (io.btn_raw),
    .dout    (btn_lvl)
  );

  // Rising-edge detect on the debounced level; release never pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_lvl_d <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      btn_lvl_d <= btn_lvl;
      step_q    <= btn_lvl & ~btn_lvl_d;
    end
  end

  assign io.w         = w_lvl;
  assign io.btn_level = btn_lvl;
  assign io.step      = step_q;

endmodule
